// File: rtl/sm3_msg_ctrl.sv
// SM3 message controller: packs a big-endian word stream into 512-bit blocks,
// appends SM3 padding and the 64-bit length, and chains sm3_core compressions.
module sm3_msg_ctrl #(
  parameter logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_init,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [31:0]  i_data,
  input  logic         i_last,
  input  logic [1:0]   i_last_bytes,
  output logic         o_core_start,
  output logic [511:0] o_core_data,
  output logic [255:0] o_core_vin,
  input  logic [255:0] i_core_vout,
  input  logic         i_core_done,
  output logic [255:0] o_digest,
  output logic         o_digest_valid,
  output logic         o_busy
);

  typedef enum logic [2:0] {IDLE, LOAD, HASH, PAD1, PAD2, DONE} state_t;

  state_t       state, state_nxt;
  state_t       after, after_nxt;
  logic [511:0] blk;
  logic [255:0] chain;
  logic [63:0]  bitcnt;
  logic [3:0]   idx;
  logic [6:0]   nbytes;
  logic         start_q;
  logic [255:0] digest;

  logic         accept;
  logic         init_ok;
  logic [2:0]   wbytes;
  logic [6:0]   n_now;
  logic [3:0]   wsel;

  // Final block: 0x80 right after the message bytes, zeros after it, and the
  // length in the last 8 bytes only when it still fits (n <= 55).
  function automatic logic [511:0] pad1_blk(input logic [511:0] b,
                                            input logic [6:0]   n,
                                            input logic [63:0]  len);
    logic [511:0] r;
    logic [6:0]   kb;
    r = b;
    for (int k = 0; k < 64; k++) begin
      kb = 7'(k);
      if (kb == n)
        r[511-8*k -: 8] = 8'h80;
      else if (kb > n)
        r[511-8*k -: 8] = 8'h00;
    end
    if (n <= 7'd55)
      r[63:0] = len;
    return r;
  endfunction

  function automatic logic [511:0] pad2_blk(input logic       mark,
                                            input logic [63:0] len);
    logic [511:0] r;
    r = '0;
    if (mark)
      r[511:504] = 8'h80;
    r[63:0] = len;
    return r;
  endfunction

  assign o_ready        = (state == LOAD);
  assign accept         = o_ready & i_valid;
  assign init_ok        = i_init && ((state == IDLE) || (state == DONE));
  assign wbytes         = (i_last && (i_last_bytes != 2'd0)) ? {1'b0, i_last_bytes} : 3'd4;
  assign n_now          = {1'b0, idx, 2'b00} + {4'd0, wbytes};
  assign wsel           = 4'd15 - idx;

  assign o_core_start   = start_q;
  assign o_core_data    = blk;
  assign o_core_vin     = chain;
  assign o_digest       = digest;
  assign o_digest_valid = (state == DONE);
  assign o_busy         = (state != IDLE) && (state != DONE);

  // after_nxt records where HASH returns once the core reports done.
  always_comb begin
    state_nxt = state;
    after_nxt = after;
    case (state)
      IDLE: if (i_init) state_nxt = LOAD;
      DONE: state_nxt = i_init ? LOAD : IDLE;
      LOAD: begin
        if (accept) begin
          if (i_last) begin
            if (n_now == 7'd64) begin
              state_nxt = HASH;
              after_nxt = PAD2;
            end else begin
              state_nxt = PAD1;
            end
          end else if (idx == 4'd15) begin
            state_nxt = HASH;
            after_nxt = LOAD;
          end
        end
      end
      PAD1: begin
        state_nxt = HASH;
        after_nxt = (nbytes <= 7'd55) ? DONE : PAD2;
      end
      PAD2: begin
        state_nxt = HASH;
        after_nxt = DONE;
      end
      HASH: if (i_core_done) state_nxt = after;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      after   <= IDLE;
      blk     <= '0;
      chain   <= '0;
      bitcnt  <= '0;
      idx     <= '0;
      nbytes  <= '0;
      start_q <= 1'b0;
      digest  <= '0;
    end else begin
      state   <= state_nxt;
      after   <= after_nxt;
      start_q <= (state_nxt == HASH) && (state != HASH);
      if (init_ok) begin
        chain  <= IV;
        bitcnt <= '0;
        idx    <= '0;
        nbytes <= '0;
      end
      if (accept) begin
        blk[{wsel, 5'b0} +: 32] <= i_data;
        bitcnt <= bitcnt + {58'd0, wbytes, 3'd0};
        idx    <= idx + 4'd1;
        if (i_last)
          nbytes <= n_now;
      end
      if (state == PAD1)
        blk <= pad1_blk(blk, nbytes, bitcnt);
      if (state == PAD2)
        blk <= pad2_blk(nbytes == 7'd64, bitcnt);
      // Block and chaining value stay frozen for the whole HASH state.
      if ((state == HASH) && i_core_done) begin
        chain <= i_core_vout;
        idx   <= '0;
        if (after == DONE)
          digest <= i_core_vout;
      end
    end
  end

endmodule

// File: tb/tb_sm3_msg_ctrl.sv
// Bench for sm3_msg_ctrl: behavioural sm3_core responder plus a block/vin/digest
// scoreboard filled from an independent software SM3 padding and compression model.
module tb_sm3_msg_ctrl;
  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init = 1'b0;
  logic         valid = 1'b0;
  logic         last = 1'b0;
  logic [31:0]  data = '0;
  logic [1:0]   last_bytes = '0;
  logic         ready, core_start, dvalid, busy;
  logic [511:0] core_data;
  logic [255:0] core_vin, digest;
  logic [255:0] core_vout = '0;
  logic         core_done = 1'b0;

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int dig_cnt = 0;
  int exp_nblk = 0;

  logic [511:0] exp_blk[$];
  logic [255:0] exp_vin[$];
  logic [255:0] exp_dig[$];
  logic [7:0]   msg[256];

  sm3_msg_ctrl #(.IV(IV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init(init), .i_valid(valid), .o_ready(ready),
    .i_data(data), .i_last(last), .i_last_bytes(last_bytes),
    .o_core_start(core_start), .o_core_data(core_data), .o_core_vin(core_vin),
    .i_core_vout(core_vout), .i_core_done(core_done),
    .o_digest(digest), .o_digest_valid(dvalid), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w[68];
    logic [31:0] w1[64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
      ss2 = ss1 ^ rl(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + w1[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rl(bb, 9); bb = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  function automatic logic [31:0] word_of(input int w, input int len);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = (4*w + k < len) ? msg[4*w + k] : 8'hA5;
    return r;
  endfunction

  // Standard SM3 padding of msg[0..len-1], chained through the software model.
  task automatic prep(input int len, input bit use_const, input logic [255:0] cdig);
    logic [7:0]   pb[256];
    int           plen;
    logic [63:0]  bl;
    logic [255:0] v;
    logic [511:0] b;
    for (int i = 0; i < len; i++) pb[i] = msg[i];
    pb[len] = 8'h80;
    plen = len + 1;
    while (plen % 64 != 56) begin pb[plen] = 8'h00; plen++; end
    bl = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) pb[plen + k] = bl[63-8*k -: 8];
    plen += 8;
    v = IV;
    exp_nblk = plen / 64;
    for (int bi = 0; bi < exp_nblk; bi++) begin
      for (int k = 0; k < 64; k++) b[511-8*k -: 8] = pb[bi*64 + k];
      exp_blk.push_back(b);
      exp_vin.push_back(v);
      v = sm3_cf(v, b);
    end
    exp_dig.push_back(use_const ? cdig : v);
  endtask

  task automatic send_words(input int len, input int w0, input int w1, input bit gaps, input bit poke);
    int nw, t;
    bit poked;
    nw = (len + 3) / 4;
    poked = 1'b0;
    for (int w = w0; w < w1; w++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      data = word_of(w, len);
      last = (w == nw - 1);
      last_bytes = 2'(len % 4);
      valid = 1'b1;
      t = 0;
      while (!ready && t < 300) begin
        if (poke && !poked && busy) begin init = 1'b1; poked = 1'b1; end
        @(negedge clk);
        init = 1'b0;
        t++;
      end
      if (!ready) begin
        total++; bad++;
        $error("FAIL ready_timeout got=0 exp=1 word=%0d", w);
        valid = 1'b0; last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (w1 == nw) begin
      data = 32'hDEADBEEF;
      chk("ready_after_last_a", 512'(ready), '0);
      @(negedge clk);
      chk("ready_after_last_b", 512'(ready), '0);
    end
    valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_digest(input int bd, input int bs, input string tag);
    int t;
    t = 0;
    while (dig_cnt == bd && t < 3000) begin @(negedge clk); t++; end
    if (dig_cnt == bd) begin
      total++; bad++;
      $error("FAIL %s_timeout got=none exp=digest", tag);
    end
    chk({tag, "_starts"}, 512'(n_starts - bs), 512'(exp_nblk));
    chk({tag, "_blocks_left"}, 512'(exp_blk.size()), '0);
    @(negedge clk);
  endtask

  task automatic run_msg(input int len, input bit gaps, input bit poke,
                         input bit use_const, input logic [255:0] cdig, input string tag);
    int bd, bs;
    prep(len, use_const, cdig);
    bd = dig_cnt;
    bs = n_starts;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk({tag, "_ready_load"}, 512'(ready), 512'(1));
    chk({tag, "_busy_load"}, 512'(busy), 512'(1));
    send_words(len, 0, (len + 3) / 4, gaps, poke);
    wait_digest(bd, bs, tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 512'(ready), '0);
    chk({tag, "_start"}, 512'(core_start), '0);
    chk({tag, "_data"}, core_data, '0);
    chk({tag, "_vin"}, 512'(core_vin), '0);
    chk({tag, "_digest"}, 512'(digest), '0);
    chk({tag, "_dvalid"}, 512'(dvalid), '0);
    chk({tag, "_busy"}, 512'(busy), '0);
  endtask

  // Behavioural sm3_core with random latency; also checks every produced block and digest.
  initial begin : responder
    logic         active;
    int           cnt;
    logic [511:0] cap_d;
    logic [255:0] cap_v;
    active = 1'b0;
    cnt = 0;
    cap_d = '0;
    cap_v = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (dvalid) begin
          if (exp_dig.size() == 0) begin
            total++; bad++;
            $error("FAIL unexpected_digest got=%0h exp=none", digest);
          end else begin
            chk("digest", 512'(digest), 512'(exp_dig.pop_front()));
            chk("busy_at_digest", 512'(busy), '0);
          end
          dig_cnt++;
        end
        if (active) begin
          chk("data_stable", core_data, cap_d);
          chk("vin_stable", 512'(core_vin), 512'(cap_v));
          chk("start_width", 512'(core_start), '0);
          cnt--;
          if (cnt == 0) begin
            core_vout = sm3_cf(cap_v, cap_d);
            core_done = 1'b1;
            active = 1'b0;
          end
        end else if (core_start) begin
          n_starts++;
          cap_d = core_data;
          cap_v = core_vin;
          if (exp_blk.size() == 0) begin
            total++; bad++;
            $error("FAIL unexpected_start got=%0h exp=none", core_data);
          end else begin
            chk("block", core_data, exp_blk.pop_front());
            chk("vin", 512'(core_vin), 512'(exp_vin.pop_front()));
          end
          active = 1'b1;
          cnt = $urandom_range(1, 5);
        end
      end
    end
  end

  initial begin : stim
    int bs, t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 1'b0, 1'b0, 1'b1,
            256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0, "abc");

    for (int i = 0; i < 64; i++) msg[i] = 8'h61 + 8'(i % 4);
    run_msg(64, 1'b0, 1'b0, 1'b1,
            256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732, "abcd16");

    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run_msg(56, 1'b0, 1'b0, 1'b0, '0, "len56");
    run_msg(63, 1'b0, 1'b0, 1'b0, '0, "len63");

    for (int i = 0; i < 130; i++) msg[i] = 8'($urandom);
    run_msg(130, 1'b1, 1'b0, 1'b0, '0, "gaps130");

    for (int i = 0; i < 100; i++) msg[i] = 8'($urandom);
    run_msg(100, 1'b0, 1'b1, 1'b0, '0, "init_busy");

    // Reset while the first block of a 70-byte message is in the core.
    for (int i = 0; i < 70; i++) msg[i] = 8'($urandom);
    prep(70, 1'b0, '0);
    bs = n_starts;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    send_words(70, 0, 16, 1'b0, 1'b0);
    t = 0;
    while (n_starts == bs && t < 100) begin @(negedge clk); t++; end
    chk("rst_mid_started", 512'(n_starts - bs), 512'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    exp_blk.delete();
    exp_vin.delete();
    exp_dig.delete();
    rst_n = 1'b1;
    @(negedge clk);

    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 1'b0, 1'b0, 1'b1,
            256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0, "abc_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm3_msg_ctrl.md
# sm3_msg_ctrl

SM3 message controller that drives `sm3_core` from the initiator side. It accepts a 32-bit big-endian word stream, keeps the 64-bit bit-length count, and applies SM3 padding (0x80, zero fill, 64-bit length). It issues one `sm3_core` compression per 512-bit block, chaining each `o_vout` into the next `i_vin`, and presents the final 256-bit digest. It sits between a bus/DMA word source and `sm3_core`.

## Interface
- `IV`, default 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e: initial chaining value.
- `i_clk` in 1: single clock; all logic is rising-edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_init` in 1: pulse that starts a new message.
- `i_valid` in 1: input word valid.
- `o_ready` out 1: controller can accept a word.
- `i_data` in 32: message word; byte 0 is in [31:24].
- `i_last` in 1: this is the final word of the message.
- `i_last_bytes` in 2: valid bytes in the final word; 0 means 4, 1..3 means that many from the MSB side. Unused low bytes are ignored.
- `o_core_start` out 1: one-cycle start pulse to `sm3_core` `i_start`.
- `o_core_data` out 512: block to `sm3_core` `i_data`; word 0 is in [511:480].
- `o_core_vin` out 256: chaining value to `sm3_core` `i_vin`.
- `i_core_vout` in 256: from `sm3_core` `o_vout`.
- `i_core_done` in 1: from `sm3_core` `o_done`.
- `o_digest` out 256: final hash.
- `o_digest_valid` out 1: one-cycle pulse when `o_digest` is updated.
- `o_busy` out 1: high from an accepted `i_init` until `o_digest_valid`.

## Operation
- **States:**
  - IDLE
  - LOAD: fill the 16-word buffer.
  - HASH: start pulse sent, waiting for done.
  - PAD1: build the final block containing 0x80.
  - PAD2: build the extra length-only block.
  - DONE: one cycle, emits the digest.
- **Reset values:** all outputs 0, state IDLE, buffer, byte counter and chaining register all 0.
- **i_init:**
  - In IDLE it sets chaining register := IV, bitcount := 0, word index := 0, and moves to LOAD.
  - While `o_busy`=1 it is ignored.
- **LOAD:**
  - `o_ready`=1.
  - A word is accepted on `i_valid & o_ready`.
  - It is written to buffer[word index], and bitcount += 32, or 8×`i_last_bytes` for a final word with `i_last_bytes`≠0.
  - Non-last word fills index 15: go to HASH with a data block, return to LOAD afterwards.
  - Last word accepted: let n = bytes in buffer, 1..64.
    - n=64: HASH the data block, then PAD2 with the 0x80 in byte 0.
    - n≤55: PAD1 then finish.
    - 56≤n≤63: PAD1 without length, then PAD2.
- **PAD1:** byte n := 0x80 and bytes n+1..63 := 0. If n≤55, bytes 56..63 := bitcount (big-endian). Then HASH.
- **PAD2:** bytes 0..55 := 0, plus 0x80 in byte 0 if not yet placed. Bytes 56..63 := bitcount. Then HASH.
- **HASH:**
  - `o_core_start` is pulsed on entry.
  - `o_core_data` and `o_core_vin` are held stable until `i_core_done`.
  - On `i_core_done`, chaining register := `i_core_vout`, word index := 0.
  - Next state is LOAD, PAD2 or DONE as scheduled.
- **Arithmetic:**
  - bitcount is 64 bits and wraps modulo 2^64.
  - Messages are 1 byte minimum; empty messages are not supported.
- **o_ready:** 0 in every state except LOAD. After `i_last`, no words are accepted until the next `i_init`.
- **Done handling:** `i_core_done` outside HASH is ignored.
- **Reset mid-operation:** everything returns to reset values immediately. The block does not wait for the core; the next `i_init` starts clean.

## Timing
- Words are accepted at up to 1 per cycle.
- `o_ready` drops in the cycle after the 16th word or the last word is accepted.
- `o_core_start` is high the cycle after entering HASH's block-build edge, and for exactly 1 cycle.
- PAD1 and PAD2 each take 1 cycle to build the block before the start pulse.
- `o_digest` and `o_digest_valid` are registered 1 cycle after the final `i_core_done`.
- `o_busy` falls in the same cycle `o_digest_valid` rises.
- `o_digest` holds until the next final digest or reset.
- Overhead per message is the core latency times the block count, plus at most 3 cycles per block.

## Test plan
- **"abc":** `i_init`, then one word 32'h61626300 with `i_last`=1 and `i_last_bytes`=3. Require:
  - 1 `o_core_start`;
  - block equal to 61626380_0…0_00000018;
  - `o_digest`=66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0.
- **16×"abcd" (64 bytes):** require:
  - 2 start pulses;
  - the second block is 80000000_0…0_00000200, with `o_core_vin` equal to the first `i_core_vout`;
  - digest debe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732.
- **56 and 63-byte messages:** require exactly 2 start pulses:
  - 0x80 at byte 56 (or 63) of block 1;
  - block 2 zeros except length 0x1C0 (or 0x1F8);
  - digest matches the software model.
- **Back-pressure/gaps:** random `i_valid` gaps on a 130-byte message. Require:
  - 3 blocks;
  - no word accepted while `o_ready`=0;
  - `o_core_data`/`o_core_vin` stable from start to done;
  - digest matches the model.
- **`i_init` while busy:** pulse `i_init` during HASH. Require the ongoing digest to be unaffected and bitcount not cleared.
- **Reset mid-HASH:** assert `i_rst_n`=0. Require all outputs to go to 0 asynchronously; a following "abc" run yields 66c7f0f4….
